// File: rtl/regfile_avmm_be_if.sv
// Avalon-MM-style slave bus bundle for regfile_avmm_be.
// Carries address, write data/byte enables, read request and read return.
interface regfile_avmm_be_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   addr_i;
    logic                wren_i;
    logic [DATA_W-1:0]   data_i;
    logic [DATA_W/8-1:0] be_i;
    logic                rden_i;
    logic [DATA_W-1:0]   data_o;
    logic                rdvalid_o;

    modport master (
        output addr_i, wren_i, data_i, be_i, rden_i,
        input  data_o, rdvalid_o
    );

    modport slave (
        input  addr_i, wren_i, data_i, be_i, rden_i,
        output data_o, rdvalid_o
    );
endinterface

// File: rtl/regfile_avmm_be.sv
// Control/status register file with fixed-latency Avalon-MM-style read port.
// Define REGFILE_AVMM_STAT_W1C_EN for sticky write-1-to-clear status registers.
module regfile_avmm_be #(
    parameter int unsigned       STAT_CNT      = 32,
    parameter int unsigned       CTRL_CNT      = 32,
    parameter int unsigned       ADDR_W        = 7,
    parameter int unsigned       DATA_W        = 32,
    parameter bit                SEL_SR_BY_MSB = 1'b1,
    parameter int unsigned       READ_LAT      = 1,
    parameter logic [DATA_W-1:0] CTRL_RST_VAL  = '0
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    regfile_avmm_be_if.slave    bus,
    input  logic [DATA_W-1:0]   sreg_i [STAT_CNT],
    output logic [DATA_W-1:0]   creg_o [CTRL_CNT],
    output logic [CTRL_CNT-1:0] creg_wr_o,
    output logic [STAT_CNT-1:0] sreg_rd_o
);
    localparam int unsigned BE_W = DATA_W / 8;

    generate
        if (DATA_W % 8 != 0) begin : g_bad_dw
            $error("regfile_avmm_be: DATA_W must be a multiple of 8");
        end
        if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
            $error("regfile_avmm_be: READ_LAT must be 1..4");
        end
    endgenerate

    logic                sel_stat;
    logic [31:0]         idx;
    logic                ctrl_hit;
    logic                stat_hit;
    logic [DATA_W-1:0]   be_mask;
    logic [DATA_W-1:0]   rd_val;
    logic [DATA_W-1:0]   stat_val [STAT_CNT];

    logic [DATA_W-1:0]   creg_q [CTRL_CNT];
    logic [DATA_W-1:0]   creg_d [CTRL_CNT];
    logic [CTRL_CNT-1:0] creg_wr_q, creg_wr_d;
    logic [STAT_CNT-1:0] sreg_rd_q, sreg_rd_d;
    logic [READ_LAT-1:0] rv_q, rv_d;
    logic [DATA_W-1:0]   rd_q [READ_LAT];
    logic [DATA_W-1:0]   rd_d [READ_LAT];

    generate
        if (SEL_SR_BY_MSB) begin : g_msb
            assign sel_stat = bus.addr_i[ADDR_W-1];
            assign idx      = 32'(bus.addr_i[ADDR_W-2:0]);
        end else begin : g_cmp
            assign sel_stat = 32'(bus.addr_i) >= CTRL_CNT;
            assign idx      = sel_stat ? 32'(bus.addr_i) - CTRL_CNT
                                       : 32'(bus.addr_i);
        end
    endgenerate

    assign ctrl_hit = !sel_stat && (idx < CTRL_CNT);
    assign stat_hit = sel_stat && (idx < STAT_CNT);

    always_comb begin
        be_mask = '0;
        for (int k = 0; k < BE_W; k++) begin
            be_mask[8*k +: 8] = {8{bus.be_i[k]}};
        end
    end

    always_comb begin
        creg_d    = creg_q;
        creg_wr_d = '0;
        for (int i = 0; i < CTRL_CNT; i++) begin
            if (bus.wren_i && ctrl_hit && idx == i && |bus.be_i) begin
                creg_wr_d[i] = 1'b1;
                creg_d[i]    = (creg_q[i] & ~be_mask)
                             | (bus.data_i & be_mask);
            end
        end
    end

`ifdef REGFILE_AVMM_STAT_W1C_EN
    logic [DATA_W-1:0] stat_q [STAT_CNT];
    logic [DATA_W-1:0] stat_d [STAT_CNT];

    // Clear first, then OR in new events so a set in the same cycle wins.
    always_comb begin
        for (int i = 0; i < STAT_CNT; i++) begin
            stat_d[i] = stat_q[i];
            if (bus.wren_i && stat_hit && idx == i) begin
                stat_d[i] = stat_d[i] & ~(bus.data_i & be_mask);
            end
            stat_d[i] = stat_d[i] | sreg_i[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < STAT_CNT; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            stat_q <= stat_d;
        end
    end

    always_comb stat_val = stat_q;
`else
    always_comb stat_val = sreg_i;
`endif

    always_comb begin
        rd_val    = '0;
        sreg_rd_d = '0;
        for (int i = 0; i < CTRL_CNT; i++) begin
            if (ctrl_hit && idx == i) begin
                rd_val = creg_q[i];
            end
        end
        for (int i = 0; i < STAT_CNT; i++) begin
            if (stat_hit && idx == i) begin
                rd_val       = stat_val[i];
                sreg_rd_d[i] = bus.rden_i;
            end
        end
    end

    // Data stages load only behind a valid, so the tail holds between reads.
    always_comb begin
        rv_d    = '0;
        rd_d    = rd_q;
        rv_d[0] = bus.rden_i;
        if (bus.rden_i) begin
            rd_d[0] = rd_val;
        end
        for (int j = 1; j < READ_LAT; j++) begin
            rv_d[j] = rv_q[j-1];
            if (rv_q[j-1]) begin
                rd_d[j] = rd_q[j-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < CTRL_CNT; i++) begin
                creg_q[i] <= CTRL_RST_VAL;
            end
            for (int j = 0; j < READ_LAT; j++) begin
                rd_q[j] <= '0;
            end
            creg_wr_q <= '0;
            sreg_rd_q <= '0;
            rv_q      <= '0;
        end else begin
            creg_q    <= creg_d;
            rd_q      <= rd_d;
            creg_wr_q <= creg_wr_d;
            sreg_rd_q <= sreg_rd_d;
            rv_q      <= rv_d;
        end
    end

    always_comb creg_o = creg_q;
    assign creg_wr_o     = creg_wr_q;
    assign sreg_rd_o     = sreg_rd_q;
    assign bus.data_o    = rd_q[READ_LAT-1];
    assign bus.rdvalid_o = rv_q[READ_LAT-1];
endmodule
